// File: rtl/mem_arbiter_if.sv
// Per-master access port of the memory arbiter.
//   req/we/lock/addr/wdata : master -> arbiter request
//   gnt                    : arbiter -> master, access accepted this cycle
//   rvalid/rdata           : arbiter -> master, read return one cycle after a read grant
// modport master is the requester side; modport slave is the arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) ();
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing the single MEMORY port (1-cycle read latency) between
// the CPU data port (m0) and the DMA/framebuffer copy engine (m1).
//   clk, rst          : clock, synchronous active-high reset
//   m0, m1            : master ports (mem_arbiter_if.slave)
//   mem_read_o        : to MEMORY memread_i
//   mem_write_o       : to MEMORY memwrite_i
//   mem_addr_o        : to MEMORY memaddr_i
//   mem_wdata_o       : to MEMORY memwdata_i
//   mem_rdata_i       : from MEMORY memrdata_o, valid the cycle after the read
// Round-robin grant, combinational in the request cycle. A master may lock the port
// for consecutive cycles; the lock is cut after MAX_LOCK cycles if the other master waits.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

  localparam logic [7:0] CntMax = 8'(MAX_LOCK - 1);

  state_e     state_q;
  logic       last_q;
  logic [7:0] lock_cnt_q;
  logic       rd_v_q;
  logic       rd_owner_q;

  logic              gnt0, gnt1, gnt_any, sel, hold;
  logic              g_we, g_lock, other_req;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // Lock owner keeps the port only while it is still requesting.
    hold = (state_q == StLock0 && m0.req) || (state_q == StLock1 && m1.req);
    if (!rst) begin
      if (state_q == StLock0 && m0.req) begin
        gnt0 = 1'b1;
      end else if (state_q == StLock1 && m1.req) begin
        gnt1 = 1'b1;
      end else if (m0.req && m1.req) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (m0.req) begin
        gnt0 = 1'b1;
      end else if (m1.req) begin
        gnt1 = 1'b1;
      end
    end
    gnt_any   = gnt0 | gnt1;
    sel       = gnt1;
    g_we      = sel ? m1.we    : m0.we;
    g_lock    = sel ? m1.lock  : m0.lock;
    g_addr    = sel ? m1.addr  : m0.addr;
    g_wdata   = sel ? m1.wdata : m0.wdata;
    other_req = sel ? m0.req   : m1.req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
      rd_v_q     <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_v_q <= gnt_any & ~g_we;
      if (gnt_any && !g_we) rd_owner_q <= sel;

      if (hold) begin
        last_q <= sel;
        if (!g_lock) begin
          state_q <= StArb;
        end else if (other_req && lock_cnt_q == CntMax) begin
          // Forced release: last = owner, so the waiting master wins next cycle.
          state_q <= StArb;
        end else if (lock_cnt_q != CntMax) begin
          // Saturate so an idle peer never causes release later on its own.
          lock_cnt_q <= lock_cnt_q + 8'd1;
        end
      end else begin
        // Either already arbitrating, or the lock owner dropped req this cycle.
        if (state_q != StArb) lock_cnt_q <= 8'd0;
        state_q <= StArb;
        if (gnt_any) begin
          last_q <= sel;
          if (g_lock) begin
            state_q    <= sel ? StLock1 : StLock0;
            lock_cnt_q <= 8'd1;
          end
        end
      end
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  assign mem_read_o  = gnt_any & ~g_we;
  assign mem_write_o = gnt_any & g_we;
  assign mem_addr_o  = gnt_any ? g_addr  : '0;
  assign mem_wdata_o = gnt_any ? g_wdata : '0;

  // Return is suppressed combinationally while reset is held.
  assign m0.rvalid = ~rst & rd_v_q & ~rd_owner_q;
  assign m1.rvalid = ~rst & rd_v_q & rd_owner_q;
  assign m0.rdata  = m0.rvalid ? mem_rdata_i : '0;
  assign m1.rdata  = m1.rvalid ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();

  mem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .MAX_LOCK (4)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Small MEMORY stand-in with 1-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= (mem_addr == 16'h1004) ? 32'hDEADBEEF : {16'hC0DE, mem_addr};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic r0, input logic we0, input logic lk0, input logic [15:0] a0,
                       input logic r1, input logic we1, input logic lk1, input logic [15:0] a1);
    m0_if.req = r0; m0_if.we = we0; m0_if.lock = lk0; m0_if.addr = a0;
    m1_if.req = r1; m1_if.we = we1; m1_if.lock = lk1; m1_if.addr = a1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m0_if.wdata = 32'h0;
    m1_if.wdata = 32'h0;
    mem_rdata   = 32'h0;
    drive(1, 0, 0, 16'h1004, 1, 0, 0, 16'h2000);
    rst = 1'b1;
    tick();
    #1;
    // Requests during reset are ignored.
    check_eq("rst_gnt0", {31'b0, m0_if.gnt}, 32'd0);
    check_eq("rst_gnt1", {31'b0, m1_if.gnt}, 32'd0);
    check_eq("rst_rd",   {31'b0, mem_read},  32'd0);
    check_eq("rst_addr", {16'b0, mem_addr},  32'd0);

    // Single m0 read.
    do_reset();
    drive(1, 0, 0, 16'h1004, 0, 0, 0, 16'h0);
    #1;
    check_eq("t1_gnt0", {31'b0, m0_if.gnt}, 32'd1);
    check_eq("t1_rd",   {31'b0, mem_read},  32'd1);
    check_eq("t1_addr", {16'b0, mem_addr},  32'h1004);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    #1;
    check_eq("t1_rv0",   {31'b0, m0_if.rvalid}, 32'd1);
    check_eq("t1_rdata", m0_if.rdata,           32'hDEADBEEF);
    check_eq("t1_rv1",   {31'b0, m1_if.rvalid}, 32'd0);

    // Both read continuously: alternate m0, m1 starting with m0.
    do_reset();
    drive(1, 0, 0, 16'h0010, 1, 0, 0, 16'h0020);
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("t2_gnt0_c%0d", i), {31'b0, m0_if.gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("t2_gnt1_c%0d", i), {31'b0, m1_if.gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check_eq($sformatf("t2_rv0_c%0d", i), {31'b0, m0_if.rvalid},
                 (i % 2 == 1) ? 32'd1 : 32'd0);
        check_eq($sformatf("t2_rv1_c%0d", i), {31'b0, m1_if.rvalid},
                 (i % 2 == 0) ? 32'd1 : 32'd0);
        check_eq($sformatf("t2_rd0_c%0d", i), m0_if.rdata,
                 (i % 2 == 1) ? 32'hC0DE0010 : 32'h0);
      end
      tick();
    end
    drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    #1;
    check_eq("t2_last_rv1", {31'b0, m1_if.rvalid}, 32'd1);
    check_eq("t2_last_rd1", m1_if.rdata,           32'hC0DE0020);

    // m1 write, m0 idle.
    do_reset();
    drive(0, 0, 0, 16'h0, 1, 1, 0, 16'hFFF0);
    m1_if.wdata = 32'h1234;
    #1;
    check_eq("t3_gnt1",  {31'b0, m1_if.gnt}, 32'd1);
    check_eq("t3_wr",    {31'b0, mem_write}, 32'd1);
    check_eq("t3_rd",    {31'b0, mem_read},  32'd0);
    check_eq("t3_addr",  {16'b0, mem_addr},  32'hFFF0);
    check_eq("t3_wdata", mem_wdata,          32'h1234);
    tick();
    drive(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    m1_if.wdata = 32'h0;
    #1;
    check_eq("t3_rv0", {31'b0, m0_if.rvalid}, 32'd0);
    check_eq("t3_rv1", {31'b0, m1_if.rvalid}, 32'd0);

    // Lock bounded by MAX_LOCK=4: m0 x4, m1, m0.
    do_reset();
    drive(1, 0, 1, 16'h0100, 1, 0, 0, 16'h0200);
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("t4_gnt0_c%0d", i), {31'b0, m0_if.gnt}, (i == 4) ? 32'd0 : 32'd1);
      check_eq($sformatf("t4_gnt1_c%0d", i), {31'b0, m1_if.gnt}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // Lock held 3 cycles then dropped: m1 wins after the unlocked grant.
    do_reset();
    drive(1, 0, 1, 16'h0100, 1, 0, 0, 16'h0200);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) m0_if.lock = 1'b0;
      #1;
      check_eq($sformatf("t5_gnt0_c%0d", i), {31'b0, m0_if.gnt}, (i == 4) ? 32'd0 : 32'd1);
      check_eq($sformatf("t5_gnt1_c%0d", i), {31'b0, m1_if.gnt}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end

    // Reset right after a locking read grant: rvalid and memory outputs suppressed.
    do_reset();
    drive(1, 0, 1, 16'h1004, 0, 0, 0, 16'h0);
    #1;
    check_eq("t6_gnt0", {31'b0, m0_if.gnt}, 32'd1);
    tick();
    rst = 1'b1;
    drive(1, 0, 0, 16'h1004, 1, 0, 0, 16'h0300);
    #1;
    check_eq("t6_rv0",   {31'b0, m0_if.rvalid}, 32'd0);
    check_eq("t6_rdat0", m0_if.rdata,           32'd0);
    check_eq("t6_rd",    {31'b0, mem_read},     32'd0);
    check_eq("t6_wr",    {31'b0, mem_write},    32'd0);
    check_eq("t6_addr",  {16'b0, mem_addr},     32'd0);
    check_eq("t6_g0rst", {31'b0, m0_if.gnt},    32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t6_post_gnt0", {31'b0, m0_if.gnt}, 32'd1);
    check_eq("t6_post_gnt1", {31'b0, m1_if.gnt}, 32'd0);
    tick();
    #1;
    check_eq("t6_next_gnt1", {31'b0, m1_if.gnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
